// File: rtl/jtag_tap_sampled.sv
// Purpose: device-side IEEE 1149.1 TAP that oversamples TCK/TMS/TDI/TRST with clk_i; IR, BYPASS, IDCODE and one user DR.
// Latency: a TCK edge takes effect SYNC_STAGES+1 clk_i cycles after it reaches the pins; TDO follows TCK fall by the same amount.
// Backpressure: none; each TCK level must be held at least SYNC_STAGES+2 clk_i cycles or the edge may be missed.
module jtag_tap_sampled #(
    parameter int unsigned          IR_WIDTH      = 5,
    parameter logic [31:0]          IDCODE_VALUE  = 32'h249511C3,
    parameter int unsigned          USER_DR_WIDTH = 32,
    parameter int unsigned          SYNC_STAGES   = 2,
    parameter logic [IR_WIDTH-1:0]  INSTR_IDCODE  = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0]  INSTR_USER    = IR_WIDTH'(4)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     tck_i,
    input  logic                     tms_i,
    input  logic                     tdi_i,
    input  logic                     trst_ni,
    output logic                     tdo_o,
    input  logic [USER_DR_WIDTH-1:0] user_dr_capture_i,
    output logic [USER_DR_WIDTH-1:0] user_dr_o,
    output logic                     user_dr_valid_o,
    output logic [IR_WIDTH-1:0]      ir_o,
    output logic [3:0]               tap_state_o
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_t;

    // Pin synchronizers; TMS/TDI share the TCK depth so they line up with the detected edge.
    logic [SYNC_STAGES-1:0] tck_sync;
    logic [SYNC_STAGES-1:0] tms_sync;
    logic [SYNC_STAGES-1:0] tdi_sync;
    logic [SYNC_STAGES-1:0] trst_sync;
    logic                   tck_prev;

    logic tck_s, tms_s, tdi_s, trst_n_s;
    logic tck_rise, tck_fall;

    tap_state_t                state_q;
    tap_state_t                state_nxt;
    logic [IR_WIDTH-1:0]       ir_sr;
    logic [31:0]               idcode_sr;
    logic [USER_DR_WIDTH-1:0]  user_sr;
    logic                      bypass_sr;

    logic                      sel_idcode;
    logic                      sel_user;
    logic [IR_WIDTH-1:0]       ir_shifted;
    logic [31:0]               idcode_shifted;
    logic [USER_DR_WIDTH-1:0]  user_shifted;
    logic                      tdo_nxt;

    // Synchronizer history is cleared only by the system reset, never by TRST.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tck_sync  <= '0;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
            tck_prev  <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[SYNC_STAGES-2:0], tck_i};
            tms_sync  <= {tms_sync[SYNC_STAGES-2:0], tms_i};
            tdi_sync  <= {tdi_sync[SYNC_STAGES-2:0], tdi_i};
            trst_sync <= {trst_sync[SYNC_STAGES-2:0], trst_ni};
            tck_prev  <= tck_sync[SYNC_STAGES-1];
        end
    end

    assign tck_s    = tck_sync[SYNC_STAGES-1];
    assign tms_s    = tms_sync[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync[SYNC_STAGES-1];
    assign trst_n_s = trst_sync[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_prev;
    assign tck_fall = ~tck_s & tck_prev;

    // DR selection: IDCODE and USER opcodes, everything else falls back to BYPASS.
    assign sel_idcode = (ir_o == INSTR_IDCODE);
    assign sel_user   = (ir_o == INSTR_USER) && !sel_idcode;

    // Right shift with the sampled TDI entering at the MSB; the concat-and-truncate form also covers width 1.
    assign ir_shifted     = IR_WIDTH'({tdi_s, ir_sr} >> 1);
    assign idcode_shifted = 32'({tdi_s, idcode_sr} >> 1);
    assign user_shifted   = USER_DR_WIDTH'({tdi_s, user_sr} >> 1);

    // 1149.1 next-state function evaluated with the sampled TMS.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            TLR:     state_nxt = tms_s ? TLR    : RTI;
            RTI:     state_nxt = tms_s ? SEL_DR : RTI;
            SEL_DR:  state_nxt = tms_s ? SEL_IR : CAP_DR;
            CAP_DR:  state_nxt = tms_s ? EX1_DR : SH_DR;
            SH_DR:   state_nxt = tms_s ? EX1_DR : SH_DR;
            EX1_DR:  state_nxt = tms_s ? UPD_DR : PAU_DR;
            PAU_DR:  state_nxt = tms_s ? EX2_DR : PAU_DR;
            EX2_DR:  state_nxt = tms_s ? UPD_DR : SH_DR;
            UPD_DR:  state_nxt = tms_s ? SEL_DR : RTI;
            SEL_IR:  state_nxt = tms_s ? TLR    : CAP_IR;
            CAP_IR:  state_nxt = tms_s ? EX1_IR : SH_IR;
            SH_IR:   state_nxt = tms_s ? EX1_IR : SH_IR;
            EX1_IR:  state_nxt = tms_s ? UPD_IR : PAU_IR;
            PAU_IR:  state_nxt = tms_s ? EX2_IR : PAU_IR;
            EX2_IR:  state_nxt = tms_s ? UPD_IR : SH_IR;
            UPD_IR:  state_nxt = tms_s ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    // Value TDO takes on the next TCK fall: LSB of the active shift register, 0 outside shift states.
    always_comb begin
        tdo_nxt = 1'b0;
        if (state_q == SH_IR) begin
            tdo_nxt = ir_sr[0];
        end else if (state_q == SH_DR) begin
            if (sel_idcode)    tdo_nxt = idcode_sr[0];
            else if (sel_user) tdo_nxt = user_sr[0];
            else               tdo_nxt = bypass_sr;
        end
    end

    // TAP controller plus register actions; actions belong to the rise that leaves the named state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !trst_n_s) begin
            state_q         <= TLR;
            ir_o            <= INSTR_IDCODE;
            ir_sr           <= '0;
            idcode_sr       <= '0;
            user_sr         <= '0;
            bypass_sr       <= 1'b0;
            tdo_o           <= 1'b0;
            user_dr_valid_o <= 1'b0;
            // TRST abandons a shift but keeps the last delivered user value.
            if (!rst_ni) user_dr_o <= '0;
        end else begin
            user_dr_valid_o <= 1'b0;
            if (tck_rise) begin
                state_q <= state_nxt;
                case (state_q)
                    CAP_IR: ir_sr <= IR_WIDTH'(1);
                    SH_IR:  ir_sr <= ir_shifted;
                    UPD_IR: ir_o  <= ir_sr;
                    CAP_DR: begin
                        if (sel_idcode)    idcode_sr <= IDCODE_VALUE;
                        else if (sel_user) user_sr   <= user_dr_capture_i;
                        else               bypass_sr <= 1'b0;
                    end
                    SH_DR: begin
                        if (sel_idcode)    idcode_sr <= idcode_shifted;
                        else if (sel_user) user_sr   <= user_shifted;
                        else               bypass_sr <= tdi_s;
                    end
                    EX1_DR, EX2_DR: begin
                        if (tms_s && sel_user) begin
                            user_dr_o       <= user_sr;
                            user_dr_valid_o <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (state_nxt == TLR) ir_o <= INSTR_IDCODE;
            end
            if (tck_fall) tdo_o <= tdo_nxt;
        end
    end

    assign tap_state_o = state_q;

endmodule
